// File: rtl/rx_pkg.sv
// Shared definitions for the beat packer: default geometry and the packer state encoding.
package rx_pkg;

  localparam int unsigned DefW     = 3;
  localparam int unsigned DefBeats = 4;

  typedef enum logic [1:0] {
    StEmpty,
    StFill,
    StFlushPend
  } state_e;

endpackage

// File: rtl/rx_out_reg.sv
// Output word register with valid/ready hold: loads a word, holds it until the consumer takes it.
module rx_out_reg #(
  parameter int unsigned DataW = 12,
  parameter int unsigned CntW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DataW-1:0] data_i,
  input  logic [CntW-1:0]  count_i,
  input  logic             ready_i,
  output logic             free_o,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  logic             valid_q;
  logic [DataW-1:0] data_q;
  logic [CntW-1:0]  count_q;

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      count_q <= count_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_packer.sv
// Packs W-bit beats into BEATS-beat words (first beat in the LSBs), with flush of partial words.
module rx_packer
  import rx_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned BEATS = DefBeats,
  localparam int unsigned CntW = $clog2(BEATS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [W-1:0]       data_i,
  output logic               ready_o,
  input  logic               flush_i,
  output logic               valid_o,
  output logic [W*BEATS-1:0] data_o,
  output logic [CntW-1:0]    count_o,
  input  logic               ready_i
);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [W*BEATS-1:0] asm_q, asm_d;

  logic               free, pend, last_beat, accept;
  logic               load;
  logic [W*BEATS-1:0] load_data;
  logic [CntW-1:0]    load_count;

  assign pend      = (state_q == StFlushPend);
  assign last_beat = (cnt_q == CntW'(BEATS - 1));
  // The final beat is only taken when the output register can absorb the finished word.
  assign ready_o   = !(last_beat && !free && !pend) && !pend && reset;
  assign accept    = valid_i && ready_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    load       = 1'b0;
    load_data  = '0;
    load_count = '0;
    if (pend) begin
      if (free) begin
        load       = 1'b1;
        load_data  = asm_q;
        load_count = cnt_q;
        asm_d      = '0;
        cnt_d      = '0;
        state_d    = StEmpty;
      end
    end else begin
      if (accept) begin
        for (int k = 0; k < BEATS; k++) begin
          if (cnt_q == CntW'(k)) asm_d[W*k +: W] = data_i;
        end
        cnt_d = cnt_q + CntW'(1);
      end
      if (accept && last_beat) begin
        load       = 1'b1;
        load_data  = asm_d;
        load_count = CntW'(BEATS);
        asm_d      = '0;
        cnt_d      = '0;
      end else if (flush_i && cnt_d != '0) begin
        if (free) begin
          load       = 1'b1;
          load_data  = asm_d;
          load_count = cnt_d;
          asm_d      = '0;
          cnt_d      = '0;
        end else begin
          state_d = StFlushPend;
        end
      end
      if (state_d != StFlushPend) state_d = (cnt_d == '0) ? StEmpty : StFill;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  rx_out_reg #(
    .DataW(W * BEATS),
    .CntW (CntW)
  ) u_out_reg (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .data_i (load_data),
    .count_i(load_count),
    .ready_i(ready_i),
    .free_o (free),
    .valid_o(valid_o),
    .data_o (data_o),
    .count_o(count_o)
  );

endmodule

// File: tb/tb_rx_packer.sv
// Bench for rx_packer: directed vector table, reset sequence, then random traffic vs a queue model.
module tb_rx_packer;

  localparam int unsigned W     = 3;
  localparam int unsigned BEATS = 4;
  localparam int unsigned CW    = $clog2(BEATS + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               valid_i = 1'b0;
  logic               flush_i = 1'b0;
  logic               ready_i = 1'b0;
  logic [W-1:0]       data_i = '0;
  logic               ready_o, valid_o;
  logic [W*BEATS-1:0] data_o;
  logic [CW-1:0]      count_o;

  int nvec = 0;
  int nerr = 0;

  // Reference model: pending beats in arrival order, a pending-flush flag and the output slot.
  int part[$];
  bit m_pend, m_valid;
  int m_data, m_count;

  typedef struct {
    bit v; int d; bit f; bit r;
    bit e_rdy; bit e_vo; int e_data; int e_cnt;
  } vec_t;
  vec_t tab[$];

  always #5 clk = ~clk;

  rx_packer #(
    .W    (W),
    .BEATS(BEATS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .valid_i(valid_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .flush_i(flush_i),
    .valid_o(valid_o),
    .data_o (data_o),
    .count_o(count_o),
    .ready_i(ready_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_free();
    return !m_valid || ready_i;
  endfunction

  function automatic bit m_ready();
    return reset && !m_pend && !(part.size() == BEATS - 1 && !m_free());
  endfunction

  function automatic void m_emit();
    int v = 0;
    foreach (part[k]) v |= part[k] << (W * k);
    m_valid = 1'b1;
    m_data  = v;
    m_count = part.size();
    part.delete();
  endfunction

  function automatic void m_clear();
    part.delete();
    m_pend  = 1'b0;
    m_valid = 1'b0;
    m_data  = 0;
    m_count = 0;
  endfunction

  function automatic void m_edge();
    bit free, acc;
    if (!reset) return;
    free = m_free();
    acc  = valid_i && m_ready();
    if (m_valid && ready_i) m_valid = 1'b0;
    if (m_pend) begin
      if (free) begin
        m_emit();
        m_pend = 1'b0;
      end
    end else begin
      if (acc) part.push_back(int'(data_i));
      if (part.size() == BEATS) m_emit();
      else if (flush_i && part.size() > 0) begin
        if (free) m_emit();
        else m_pend = 1'b1;
      end
    end
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".ready"}, 32'(ready_o), 32'(m_ready()));
    chk({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".data"}, 32'(data_o), m_data);
      chk({tag, ".count"}, 32'(count_o), m_count);
    end
  endtask

  task automatic drive(input bit v, input int d, input bit f, input bit r);
    valid_i = v;
    data_i  = W'(d);
    flush_i = f;
    ready_i = r;
  endtask

  // One cycle: drive after the active edge, check on the falling edge, advance model on the rising.
  task automatic step(input bit v, input int d, input bit f, input bit r, input string tag);
    drive(v, d, f, r);
    @(negedge clk);
    chk_model(tag);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  function automatic void add(input bit v, input int d, input bit f, input bit r,
                              input bit e_rdy, input bit e_vo, input int e_data, input int e_cnt);
    tab.push_back('{v, d, f, r, e_rdy, e_vo, e_data, e_cnt});
  endfunction

  initial begin
    //  v  d  f  r   rdy vo data    cnt
    add(1, 1, 0, 1,  1, 0, 0,      0);  // full word 1,2,3,4
    add(1, 2, 0, 1,  1, 0, 0,      0);
    add(1, 3, 0, 1,  1, 0, 0,      0);
    add(1, 4, 0, 1,  1, 0, 0,      0);
    add(0, 0, 0, 1,  1, 1, 'h8D1,  4);
    add(0, 0, 0, 1,  1, 0, 0,      0);
    add(1, 1, 0, 0,  1, 0, 0,      0);  // output held, second word queued behind it
    add(1, 2, 0, 0,  1, 0, 0,      0);
    add(1, 3, 0, 0,  1, 0, 0,      0);
    add(1, 4, 0, 0,  1, 0, 0,      0);
    add(1, 7, 0, 0,  1, 1, 'h8D1,  4);
    add(1, 7, 0, 0,  1, 1, 'h8D1,  4);
    add(1, 7, 0, 0,  1, 1, 'h8D1,  4);
    add(1, 7, 0, 0,  0, 1, 'h8D1,  4);
    add(1, 7, 0, 0,  0, 1, 'h8D1,  4);
    add(1, 7, 0, 1,  1, 1, 'h8D1,  4);
    add(0, 0, 0, 1,  1, 1, 'hFFF,  4);
    add(0, 0, 0, 1,  1, 0, 0,      0);
    add(1, 5, 0, 1,  1, 0, 0,      0);  // partial flush with free output
    add(1, 6, 0, 1,  1, 0, 0,      0);
    add(0, 0, 1, 1,  1, 0, 0,      0);
    add(1, 2, 0, 1,  1, 1, 'h035,  2);
    add(0, 0, 1, 1,  1, 0, 0,      0);
    add(0, 0, 0, 1,  1, 1, 'h002,  1);
    add(0, 0, 0, 1,  1, 0, 0,      0);
    add(0, 0, 1, 1,  1, 0, 0,      0);  // flush with nothing collected
    add(0, 0, 0, 1,  1, 0, 0,      0);
    add(1, 1, 0, 1,  1, 0, 0,      0);  // flush on the completing beat
    add(1, 2, 0, 1,  1, 0, 0,      0);
    add(1, 3, 0, 1,  1, 0, 0,      0);
    add(1, 4, 1, 1,  1, 0, 0,      0);
    add(0, 0, 0, 1,  1, 1, 'h8D1,  4);
    add(0, 0, 0, 1,  1, 0, 0,      0);
    add(1, 1, 0, 0,  1, 0, 0,      0);  // flush blocked by held output
    add(1, 2, 0, 0,  1, 0, 0,      0);
    add(1, 3, 0, 0,  1, 0, 0,      0);
    add(1, 4, 0, 0,  1, 0, 0,      0);
    add(1, 5, 0, 0,  1, 1, 'h8D1,  4);
    add(1, 6, 1, 0,  1, 1, 'h8D1,  4);
    add(1, 7, 0, 0,  0, 1, 'h8D1,  4);
    add(0, 0, 0, 0,  0, 1, 'h8D1,  4);
    add(0, 0, 0, 1,  0, 1, 'h8D1,  4);
    add(0, 0, 0, 1,  1, 1, 'h035,  2);
    add(0, 0, 0, 1,  1, 0, 0,      0);

    m_clear();
    @(posedge clk);
    #1;
    chk("rst.ready", 32'(ready_o), 0);
    chk("rst.valid", 32'(valid_o), 0);
    chk("rst.data", 32'(data_o), 0);
    chk("rst.count", 32'(count_o), 0);
    reset = 1'b1;

    foreach (tab[i]) begin
      drive(tab[i].v, tab[i].d, tab[i].f, tab[i].r);
      @(negedge clk);
      chk($sformatf("tab%0d.ready", i), 32'(ready_o), 32'(tab[i].e_rdy));
      chk($sformatf("tab%0d.valid", i), 32'(valid_o), 32'(tab[i].e_vo));
      if (tab[i].e_vo) begin
        chk($sformatf("tab%0d.data", i), 32'(data_o), tab[i].e_data);
        chk($sformatf("tab%0d.count", i), 32'(count_o), tab[i].e_cnt);
      end
      chk_model($sformatf("tab%0d.model", i));
      @(posedge clk);
      m_edge();
      #1;
    end

    // Reset mid-operation: a held word plus three collected beats must vanish.
    for (int i = 1; i <= 7; i++) step(1'b1, i, 1'b0, 1'b0, "pre_rst");
    #2 reset = 1'b0;
    #1;
    m_clear();
    chk("arst.valid", 32'(valid_o), 0);
    chk("arst.data", 32'(data_o), 0);
    chk("arst.count", 32'(count_o), 0);
    chk("arst.ready", 32'(ready_o), 0);
    step(1'b1, 5, 1'b1, 1'b1, "in_rst");
    step(1'b1, 6, 1'b0, 1'b1, "in_rst");
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b1, "post_rst");
    drive(1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_rst.word", 32'(data_o), 'h8D1);
    chk("post_rst.cnt", 32'(count_o), 4);
    chk_model("post_rst");
    @(posedge clk);
    m_edge();
    #1;

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
